// File: rtl/ga_pkg.sv
// Shared definitions for the GA breeding stage: RAM command encodings,
// FSM state encoding and the genome word address calculation.
package ga_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PICK,
        S_RD_A,
        S_WAIT_A,
        S_RD_B,
        S_WAIT_B,
        S_WR,
        S_WAIT_W,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    // Sum is formed at 32 bits and truncated, so addresses wrap silently at 2^23.
    function automatic logic [22:0] genome_addr(
        input logic [22:0] base,
        input int unsigned slot,
        input int unsigned word,
        input int unsigned words_per_genome
    );
        logic [31:0] sum;
        sum = 32'(base) + slot * words_per_genome + word;
        return sum[22:0];
    endfunction

endpackage

// File: rtl/ga_mutator.sv
// Uniform-crossover word select plus sparse single-bit mutation; purely
// combinational so the child word is ready in the same cycle as the write.
module ga_mutator (
    input  logic [15:0] i_word_a,
    input  logic [15:0] i_word_b,
    input  logic [7:0]  i_rnd,
    input  logic [7:0]  i_thresh,
    output logic [15:0] o_child
);

    logic [15:0] w_pick;
    logic [15:0] w_flip;

    // One random byte drives both the parent select and the mutation decision.
    assign w_pick  = i_rnd[7] ? i_word_b : i_word_a;
    assign w_flip  = (i_rnd < i_thresh) ? (16'h0001 << i_rnd[3:0]) : 16'h0000;
    assign o_child = w_pick ^ w_flip;

endmodule

// File: rtl/ga_crossover.sv
// Breeding pass: rewrites every non-elite genome slot in RAM word by word with
// a mutated uniform-crossover child of two distinct elite parents.
module ga_crossover
    import ga_pkg::*;
#(
    parameter int          NUM_NETWORKS = 10,
    parameter int          GENOME_WORDS = 64,
    parameter int          ELITE_LOG2   = 1,
    parameter logic [7:0]  MUT_THRESH   = 8'd4,
    parameter logic [22:0] BASE_ADDR    = 23'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  randomnum,
    output logic        cross_finished,
    output logic        busy,
    output logic        ram_instruction,
    output logic        ram_latch,
    output logic [22:0] ram_addr,
    output logic [15:0] ram_data_wr,
    input  logic [15:0] ram_data_rd,
    input  logic        ram_ready
);

    localparam int ELITE   = 1 << ELITE_LOG2;
    localparam int CHILD_W = $clog2(NUM_NETWORKS + 1);
    localparam int WORD_W  = (GENOME_WORDS > 1) ? $clog2(GENOME_WORDS) : 1;
    localparam bit DEGEN   = (NUM_NETWORKS <= ELITE);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CHILD_W-1:0]    r_child;
    logic [WORD_W-1:0]     r_word;
    logic [ELITE_LOG2-1:0] r_pa;
    logic [ELITE_LOG2-1:0] w_pb;
    logic                  r_seen_low;
    logic                  r_busy;
    logic                  r_cross;
    logic [15:0]           r_word_a;
    logic [15:0]           r_word_b;
    logic [15:0]           w_child_word;
    logic                  w_is_wait;
    logic                  w_accept;
    logic                  w_cap_a;
    logic                  w_cap_b;
    logic                  w_latch;
    logic                  w_instr;
    logic [22:0]           w_addr;
    logic [15:0]           w_wdata;

    assign w_pb      = r_pa + 1'b1;
    assign w_is_wait = (r_state == S_WAIT_A) || (r_state == S_WAIT_B) || (r_state == S_WAIT_W);

    ga_mutator u_mutator (
        .i_word_a (r_word_a),
        .i_word_b (r_word_b),
        .i_rnd    (randomnum),
        .i_thresh (MUT_THRESH),
        .o_child  (w_child_word)
    );

    // Bus outputs default to zero so that IDLE leaves the shared bus clear.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cap_a     = 1'b0;
        w_cap_b     = 1'b0;
        w_latch     = 1'b0;
        w_instr     = RAM_READ;
        w_addr      = 23'd0;
        w_wdata     = 16'd0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_busy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DEGEN ? S_DONE : S_PICK;
                end
            end
            S_PICK: w_state_nxt = S_RD_A;
            S_RD_A: begin
                if (ram_ready) begin
                    w_latch     = 1'b1;
                    w_addr      = genome_addr(BASE_ADDR, 32'(r_pa), 32'(r_word), GENOME_WORDS);
                    w_state_nxt = S_WAIT_A;
                end
            end
            S_WAIT_A: begin
                if (ram_ready && r_seen_low) begin
                    w_cap_a     = 1'b1;
                    w_state_nxt = S_RD_B;
                end
            end
            S_RD_B: begin
                if (ram_ready) begin
                    w_latch     = 1'b1;
                    w_addr      = genome_addr(BASE_ADDR, 32'(w_pb), 32'(r_word), GENOME_WORDS);
                    w_state_nxt = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (ram_ready && r_seen_low) begin
                    w_cap_b     = 1'b1;
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (ram_ready) begin
                    w_latch     = 1'b1;
                    w_instr     = RAM_WRITE;
                    w_addr      = genome_addr(BASE_ADDR, 32'(r_child), 32'(r_word), GENOME_WORDS);
                    w_wdata     = w_child_word;
                    w_state_nxt = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                if (ram_ready && r_seen_low) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (r_word < WORD_W'(GENOME_WORDS - 1))
                    w_state_nxt = S_RD_A;
                else if (r_child < CHILD_W'(NUM_NETWORKS - 1))
                    w_state_nxt = S_PICK;
                else
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_child    <= '0;
            r_word     <= '0;
            r_pa       <= '0;
            r_seen_low <= 1'b0;
            r_busy     <= 1'b0;
            r_cross    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cross    <= (r_state == S_DONE);
            // A wait completes only after ready has been seen low at least once.
            r_seen_low <= w_is_wait && (w_state_nxt == r_state) && (r_seen_low || !ram_ready);
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_child <= CHILD_W'(ELITE);
                r_word  <= '0;
            end else if (r_cross) begin
                r_busy  <= 1'b0;
            end
            if (r_state == S_PICK) r_pa <= randomnum[ELITE_LOG2-1:0];
            if (r_state == S_NEXT) begin
                if (r_word < WORD_W'(GENOME_WORDS - 1)) begin
                    r_word <= r_word + 1'b1;
                end else if (r_child < CHILD_W'(NUM_NETWORKS - 1)) begin
                    r_child <= r_child + 1'b1;
                    r_word  <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap_a) r_word_a <= ram_data_rd;
        if (w_cap_b) r_word_b <= ram_data_rd;
    end

    assign ram_latch       = w_latch;
    assign ram_instruction = w_instr;
    assign ram_addr        = w_addr;
    assign ram_data_wr     = w_wdata;
    assign busy            = r_busy;
    assign cross_finished  = r_cross;

endmodule

// File: tb/tb_ga_crossover.sv
// Bench for ga_crossover: a small RAM model with a slow ready handshake, a
// write scoreboard, and a second instance configured with no breedable slots.
module tb_ga_crossover;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        hold = 1'b0;
    logic        split = 1'b0;
    logic        mem_init = 1'b0;
    logic [7:0]  rnd = 8'h10;
    logic [7:0]  randomnum;
    logic        cross_finished, busy, ram_instruction, ram_latch, ram_ready;
    logic [22:0] ram_addr;
    logic [15:0] ram_data_wr, ram_data_rd;
    logic        cross2, busy2, instr2, latch2;
    logic [22:0] addr2;
    logic [15:0] wdata2;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] mem [0:15];
    logic [15:0] rd_data;
    logic [2:0]  ph;
    logic        rd_odd, wr_phase;
    int          rd_total;
    logic [38:0] wr_q  [$];
    logic [38:0] exp_q [$];

    assign ram_ready   = hold ? 1'b0 : (ph < 3'd2);
    assign ram_data_rd = rd_data;
    assign randomnum   = (split && wr_phase) ? 8'h03 : rnd;

    ga_crossover #(.NUM_NETWORKS(4), .GENOME_WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .randomnum(randomnum),
        .cross_finished(cross_finished), .busy(busy),
        .ram_instruction(ram_instruction), .ram_latch(ram_latch),
        .ram_addr(ram_addr), .ram_data_wr(ram_data_wr),
        .ram_data_rd(ram_data_rd), .ram_ready(ram_ready)
    );

    ga_crossover #(.NUM_NETWORKS(2), .GENOME_WORDS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .randomnum(rnd),
        .cross_finished(cross2), .busy(busy2),
        .ram_instruction(instr2), .ram_latch(latch2),
        .ram_addr(addr2), .ram_data_wr(wdata2),
        .ram_data_rd(16'h0000), .ram_ready(1'b1)
    );

    // RAM model: ready stays high the cycle after a latch, low for 3 cycles, then high.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i < 4) ? 16'hAAAA : ((i < 8) ? 16'h5555 : 16'h0000);
            ph <= 3'd0; rd_odd <= 1'b0; wr_phase <= 1'b0; rd_data <= 16'h0000; rd_total <= 0;
        end else if (ram_latch) begin
            ph <= 3'd1;
            if (ram_instruction) begin
                if (ram_addr < 23'd16) mem[ram_addr[3:0]] <= ram_data_wr;
                wr_q.push_back({ram_addr, ram_data_wr});
                wr_phase <= 1'b0;
            end else begin
                rd_data  <= (ram_addr < 23'd16) ? mem[ram_addr[3:0]] : 16'hDEAD;
                rd_odd   <= ~rd_odd;
                rd_total <= rd_total + 1;
                if (rd_odd) wr_phase <= 1'b1;
            end
        end else if (ph == 3'd4) begin
            ph <= 3'd0;
        end else if (ph != 3'd0) begin
            ph <= ph + 3'd1;
        end
    end

    task automatic push_expected(input logic [15:0] d);
        exp_q.delete();
        wr_q.delete();
        for (int s = 2; s < 4; s++)
            for (int w = 0; w < 4; w++)
                exp_q.push_back({23'(s * 4 + w), d});
    endtask

    task automatic do_pass(input bit do_start, input bit mid_start, output int dones, output bit tout);
        int after;
        after = -1;
        dones = 0;
        if (do_start) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = mid_start && (c == 40);
            if (cross_finished) begin
                dones++;
                if (after < 0) after = 0;
            end
            if (after >= 0) begin
                after++;
                if (after > 10) break;
            end
        end
        start = 1'b0;
        tout = (dones == 0);
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_init = 1'b1;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        n_vec++;
        if ({ram_latch, ram_instruction, ram_addr, ram_data_wr} !== 41'd0) begin
            n_bad++; $display("FAIL reset_bus got %h want 0", {ram_latch, ram_instruction, ram_addr, ram_data_wr});
        end
        n_vec++;
        if ({busy, cross_finished, busy2, cross2} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 0000", {busy, cross_finished, busy2, cross2});
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, ram_latch, ram_addr} !== 25'd0) begin
            n_bad++; $display("FAIL post_reset_idle got %h want 0", {busy, ram_latch, ram_addr});
        end
    endtask

    task automatic test_select_a;
        int d; bit t; logic [38:0] e, a;
        rnd = 8'h10; split = 1'b0;
        push_expected(16'hAAAA);
        do_pass(1'b1, 1'b0, d, t);
        n_vec++;
        if (t || d != 1) begin n_bad++; $display("FAIL select_a_done got %0d want 1", d); end
        n_vec++;
        if (wr_q.size() != 8) begin n_bad++; $display("FAIL select_a_count got %0d want 8", wr_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front(); a = wr_q.pop_front(); n_vec++;
            if (a !== e) begin n_bad++; $display("FAIL select_a_write got %h want %h", a, e); end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); n_vec++;
            if ({ram_latch, ram_instruction, ram_addr, ram_data_wr, busy} !== 42'd0) begin
                n_bad++; $display("FAIL idle_bus got %h want 0", {ram_latch, ram_instruction, ram_addr, ram_data_wr});
            end
        end
    endtask

    task automatic test_select_b_with_restart;
        int d; bit t; logic [38:0] e, a;
        rnd = 8'h80; split = 1'b0;
        push_expected(16'h5555);
        do_pass(1'b1, 1'b1, d, t);
        n_vec++;
        if (t || d != 1) begin n_bad++; $display("FAIL busy_restart_done got %0d want 1", d); end
        n_vec++;
        if (wr_q.size() != 8) begin n_bad++; $display("FAIL select_b_count got %0d want 8", wr_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front(); a = wr_q.pop_front(); n_vec++;
            if (a !== e) begin n_bad++; $display("FAIL select_b_write got %h want %h", a, e); end
        end
    endtask

    task automatic test_reset_mid_pass;
        int base, d, seen; bit t, reached; logic [38:0] e, a;
        rnd = 8'h10; split = 1'b0; base = rd_total; reached = 1'b0; seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rd_total >= base + 2) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!reached) begin n_bad++; $display("FAIL reach_wait_b got %0d reads want 2", rd_total - base); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, cross_finished, ram_latch, ram_instruction, ram_addr, ram_data_wr} !== 43'd0) begin
            n_bad++; $display("FAIL mid_reset_outputs got %h want 0", {busy, cross_finished, ram_latch, ram_addr});
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cross_finished || busy || ram_latch) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_bad++; $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen); end
        push_expected(16'hAAAA);
        do_pass(1'b1, 1'b0, d, t);
        n_vec++;
        if (t || d != 1) begin n_bad++; $display("FAIL restart_done got %0d want 1", d); end
        n_vec++;
        if (wr_q.size() != 8) begin n_bad++; $display("FAIL restart_count got %0d want 8", wr_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front(); a = wr_q.pop_front(); n_vec++;
            if (a !== e) begin n_bad++; $display("FAIL restart_write got %h want %h", a, e); end
        end
    endtask

    task automatic test_mutation;
        int d; bit t; logic [38:0] e, a;
        rnd = 8'h10; split = 1'b1;
        push_expected(16'hAAA2);
        do_pass(1'b1, 1'b0, d, t);
        split = 1'b0;
        n_vec++;
        if (t || d != 1) begin n_bad++; $display("FAIL mutation_done got %0d want 1", d); end
        n_vec++;
        if (wr_q.size() != 8) begin n_bad++; $display("FAIL mutation_count got %0d want 8", wr_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front(); a = wr_q.pop_front(); n_vec++;
            if (a !== e) begin n_bad++; $display("FAIL mutation_write got %h want %h", a, e); end
        end
    endtask

    task automatic test_ready_hold;
        int latches, d; bit t;
        rnd = 8'h10; split = 1'b0; latches = 0;
        @(negedge clk); start = 1'b1; hold = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ram_latch) latches++;
        end
        n_vec++;
        if (latches != 0) begin n_bad++; $display("FAIL hold_no_latch got %0d want 0", latches); end
        hold = 1'b0;
        #1;
        n_vec++;
        if ({ram_latch, ram_instruction, ram_addr} !== {1'b1, 1'b0, 23'd0}) begin
            n_bad++; $display("FAIL hold_release_read got %h want %h", {ram_latch, ram_instruction, ram_addr}, {1'b1, 1'b0, 23'd0});
        end
        @(negedge clk);
        n_vec++;
        if (ram_latch !== 1'b0) begin n_bad++; $display("FAIL latch_width got %b want 0", ram_latch); end
        do_pass(1'b0, 1'b0, d, t);
        n_vec++;
        if (t || d != 1) begin n_bad++; $display("FAIL hold_done got %0d want 1", d); end
        wr_q.delete();
    endtask

    task automatic test_degenerate;
        int dones, latches;
        dones = 0; latches = 0;
        @(negedge clk); start2 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start2 = (i < 3);
            if (cross2) dones++;
            if (latch2 || instr2 || addr2 != 23'd0 || wdata2 != 16'd0) latches++;
            if (i == 1) begin
                n_vec++;
                if ({busy2, cross2} !== 2'b10) begin n_bad++; $display("FAIL degen_cycle1 got %b want 10", {busy2, cross2}); end
            end
            if (i == 2) begin
                n_vec++;
                if ({busy2, cross2} !== 2'b11) begin n_bad++; $display("FAIL degen_cycle2 got %b want 11", {busy2, cross2}); end
            end
            if (i == 3) begin
                n_vec++;
                if ({busy2, cross2} !== 2'b00) begin n_bad++; $display("FAIL degen_cycle3 got %b want 00", {busy2, cross2}); end
            end
        end
        n_vec++;
        if (dones != 1) begin n_bad++; $display("FAIL degen_done_count got %0d want 1", dones); end
        n_vec++;
        if (latches != 0) begin n_bad++; $display("FAIL degen_bus got %0d active cycles want 0", latches); end
    endtask

    initial begin
        test_reset();
        test_select_a();
        test_select_b_with_restart();
        test_reset_mid_pass();
        test_mutation();
        test_ready_hold();
        test_degenerate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ga_crossover.md
Name: ga_crossover

Overview:
- Genetic-algorithm breeding stage. Runs after the bubble sort has ordered the network genomes in external RAM by fitness, fittest at slot 0.
- Keeps the top ELITE genomes unchanged. Overwrites every other slot with a uniform-crossover child of two elite parents, then applies sparse point mutation.
- Shares the RAM command bus with the initializer, sort and network blocks. Drives the bus only while busy. Reports completion to network control as the crossover-finished pulse.

Parameters:
- NUM_NETWORKS, 10, number of genome slots in RAM.
- GENOME_WORDS, 64, 16-bit words per genome; power of 2.
- ELITE_LOG2, 1, log2 of elite count; ELITE = 2^ELITE_LOG2 = 2.
- MUT_THRESH, 8'd4, a word is mutated when the sampled random byte < MUT_THRESH (probability 4/256).
- BASE_ADDR, 23'd0, RAM word address of slot 0. Slot n word w is at BASE_ADDR + n*GENOME_WORDS + w.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a breeding pass. Ignored unless IDLE.
- randomnum  in  8  free-running PN byte, sampled per use.
- cross_finished  out  1  one-cycle pulse when the pass completes.
- busy  out  1  high from the start-accept cycle until the cross_finished cycle inclusive.
- ram_instruction  out  1  0 = READ, 1 = WRITE.
- ram_latch  out  1  one-cycle command strobe.
- ram_addr  out  23  RAM word address.
- ram_data_wr  out  16  write data.
- ram_data_rd  in  16  read data from the RAM controller.
- ram_ready  in  1  controller idle/ready.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset mid-pass abandons any in-flight RAM operation; no done pulse is emitted.
- Bus sharing: ram_instruction, ram_latch, ram_addr and ram_data_wr are forced to 0 whenever the FSM is in IDLE. This allows OR-combining with the other bus masters.
- RAM handshake:
  - A command is issued only in a cycle where ram_ready=1.
  - ram_latch=1 for exactly one cycle, with ram_addr, ram_instruction and ram_data_wr valid in that same cycle.
  - The FSM then waits until ram_ready is sampled 0 at least once, then waits for ram_ready=1.
  - Read data is captured from ram_data_rd in the cycle ram_ready returns to 1.
- FSM states: IDLE, PICK, RD_A, WAIT_A, RD_B, WAIT_B, WR, WAIT_W, NEXT, DONE.
  - IDLE: on start go to PICK, set child = ELITE, word = 0, busy = 1.
  - PICK: pA = randomnum[ELITE_LOG2-1:0]; pB = (pA+1) mod ELITE, so parents are always distinct; go to RD_A.
  - RD_A: when ram_ready, issue READ of slot pA, word `word`; go to WAIT_A. WAIT_A: capture wordA; go to RD_B.
  - RD_B and WAIT_B: same as RD_A/WAIT_A for slot pB; capture wordB.
  - WR: child word = randomnum[7] ? wordB : wordA. If randomnum < MUT_THRESH, XOR the child word with (16'h1 << randomnum[3:0]).
    - The same randomnum sample is used for both decisions.
    - The same cycle issues WRITE to slot `child`, word `word`, when ram_ready. If ram_ready=0, stay in WR and re-evaluate next cycle with the new random sample.
    - Then go to WAIT_W.
  - WAIT_W: on write completion go to NEXT.
  - NEXT:
    - If word < GENOME_WORDS-1: word++, go to RD_A.
    - Else if child < NUM_NETWORKS-1: child++, word = 0, go to PICK (new parents chosen per child).
    - Else go to DONE.
  - DONE: cross_finished = 1 for one cycle; busy is still 1 in this cycle. Next state IDLE.
- Degenerate case: NUM_NETWORKS <= ELITE gives IDLE -> DONE directly with zero RAM traffic; cross_finished fires 2 cycles after start.
- Elite slots 0..ELITE-1 are never written.
- Address arithmetic is 23-bit; the sum is truncated and wraps with no error flag.
- A start pulse while busy is ignored.
- Minimum latency per word is 3 RAM transactions.

Decomposition:
- Shared package ga_pkg: READ/WRITE encodings, FSM state encoding, a genome address function (base, slot, word → 23-bit).
- One natural sub-module: ga_mutator, combinational (wordA, wordB, rnd, thresh → child word), so it can be unit-tested on its own.

Test Plan:
- Bench RAM model: ready drops 1 cycle after latch and returns 3 cycles later. Setup: NUM_NETWORKS=4, GENOME_WORDS=4; slot 0 words = 16'hAAAA, slot 1 words = 16'h5555. Forced randomnum=8'h80 -> slots 2 and 3 all read 16'h5555, with no mutation because 8'h80 >= 4. Then randomnum=8'h10 -> all children = 16'hAAAA.
- Forced randomnum=8'h03 at WR (< MUT_THRESH, bit index 3, randomnum[7]=0 selects wordA) -> child word = 16'hAAAA ^ 16'h0008 = 16'hAAA2.
- Hold ram_ready=0 for 20 cycles at PICK->RD_A -> no ram_latch during the hold. The read issues in the first cycle ready=1, and ram_latch stays exactly one cycle wide.
- Assert rst mid-WAIT_B -> next cycle all outputs 0 and busy=0; no cross_finished. A later start completes normally.
- NUM_NETWORKS=2 -> cross_finished pulses 2 cycles after start with no ram_latch. A start pulsed during a busy pass causes no restart; done count is 1.
- Bus outputs are 0 in every IDLE cycle. Across a full pass, the count of RAM writes = (NUM_NETWORKS-ELITE)*GENOME_WORDS = 8, and no write targets slots 0-1.
